svc_rv_bpred_btb: RTL

// - Parametrised branch predictor for the pipelined RV core: direct-mapped
//   BTB, with a saturating direction counter per entry.
// - Successor to the fixed BPRED=1 static scheme. Generalised in depth,
//   tag width and counter width; adds an init sweep and optional gshare.
// - Sits beside the fetch stage: lookup PC in IF, prediction in ID.

---
 rtl/svc_rv_bpred_btb_if.sv | 30 +++
 rtl/svc_rv_bpred_btb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/svc_rv_bpred_btb_if.sv
// Fetch/execute-side bundle for the BTB branch predictor: lookup request,
// registered prediction, resolved-branch update and init status.
interface svc_rv_bpred_btb_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6
);
    logic             lookup_en;
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_hit;
    logic [XLEN-1:0]  pred_target;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_en;
    logic [XLEN-1:0]  upd_pc;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             init_busy;

    modport master (
        output lookup_en, lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
        input  pred_valid, pred_taken, pred_hit, pred_target, pred_idx, init_busy
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
        output pred_valid, pred_taken, pred_hit, pred_target, pred_idx, init_busy
    );
endinterface

// File: rtl/svc_rv_bpred_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters and an init sweep.
// Optional gshare indexing is enabled by defining SVC_RV_BPRED_GSHARE_EN.
module svc_rv_bpred_btb #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CNT_W = 2,
    parameter int GHR_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    svc_rv_bpred_btb_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             busy_r;

    logic             ent_valid  [DEPTH];
    logic [TAG_W-1:0] ent_tag    [DEPTH];
    logic [XLEN-1:0]  ent_target [DEPTH];
    logic [CNT_W-1:0] ent_cnt    [DEPTH];

    logic             vld_p1;
    logic             taken_p1;
    logic             hit_p1;
    logic [XLEN-1:0]  target_p1;
    logic [IDX_W-1:0] idx_p1;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             unused_pc;

`ifdef SVC_RV_BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    // History advances only on resolved branches, so it is never speculative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (state == RUN && bp.upd_en) begin
            ghr <= (ghr << 1) | GHR_W'(bp.upd_taken);
        end
    end

    assign lk_idx = bp.lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
    assign lk_idx = bp.lookup_pc[IDX_W+1:2];
`endif

    assign lk_tag    = bp.lookup_pc[IDX_W+2 +: TAG_W];
    assign lk_hit    = (state == RUN) && ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
    assign up_tag    = bp.upd_pc[IDX_W+2 +: TAG_W];
    assign up_hit    = ent_valid[bp.upd_idx] && (ent_tag[bp.upd_idx] == up_tag);
    assign unused_pc = ^{bp.lookup_pc, bp.upd_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT;
            ptr    <= '0;
            busy_r <= 1'b1;
        end else if (state == INIT) begin
            ptr <= ptr + IDX_W'(1);
            if (ptr == IDX_W'(DEPTH - 1)) begin
                state  <= RUN;
                busy_r <= 1'b0;
            end
        end
    end

    // Table storage: no reset, cleared by the sweep. Nonblocking writes give
    // read-first behaviour against a same-cycle lookup.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            ent_valid[ptr] <= 1'b0;
            ent_cnt[ptr]   <= CNT_WNT;
        end else if (bp.upd_en) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    ent_cnt[bp.upd_idx]    <= cnt_inc(ent_cnt[bp.upd_idx]);
                    ent_target[bp.upd_idx] <= bp.upd_target;
                end else begin
                    ent_cnt[bp.upd_idx] <= cnt_dec(ent_cnt[bp.upd_idx]);
                end
            end else if (bp.upd_taken) begin
                ent_valid[bp.upd_idx]  <= 1'b1;
                ent_tag[bp.upd_idx]    <= up_tag;
                ent_target[bp.upd_idx] <= bp.upd_target;
                ent_cnt[bp.upd_idx]    <= CNT_WT;
            end
        end
    end

    // IF -> ID boundary: prediction registered one cycle after lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            taken_p1  <= 1'b0;
            hit_p1    <= 1'b0;
            target_p1 <= '0;
            idx_p1    <= '0;
        end else begin
            vld_p1 <= bp.lookup_en;
            if (bp.lookup_en) begin
                hit_p1    <= lk_hit;
                taken_p1  <= lk_hit && ent_cnt[lk_idx][CNT_W-1];
                target_p1 <= lk_hit ? ent_target[lk_idx] : '0;
                idx_p1    <= lk_idx;
            end
        end
    end

    assign bp.pred_valid  = vld_p1;
    assign bp.pred_taken  = taken_p1;
    assign bp.pred_hit    = hit_p1;
    assign bp.pred_target = target_p1;
    assign bp.pred_idx    = idx_p1;
    assign bp.init_busy   = busy_r;
endmodule
